regfile_dump: RTL and testbench

- Read-side sequencer for the 2^D x W register file.
- On request, walks an address range through one combinational read port and streams each (address, data) pair to the testbench/debug sink over a valid/ready handshake.
- Used for end-of-program register checking and mid-run snapshots.
- Owns the read port only; never writes the register file.

---
 rtl/regfile_dump_pkg.sv | 14 +
 rtl/regfile_dump_if.sv | 29 ++
 rtl/regfile_dump.sv | 99 +++++++++
 tb/tb_regfile_dump.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and register-file geometry for the register dump sequencer.
package regfile_dump_pkg;

  localparam int REG_W = 8;
  localparam int REG_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FIN
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Dump request, register-file read port and word-stream handshake bundle.
interface regfile_dump_if #(
  parameter int W = regfile_dump_pkg::REG_W,
  parameter int D = regfile_dump_pkg::REG_D
);

  logic         DumpStart;
  logic [D-1:0] FirstAddr;
  logic [D-1:0] LastAddr;
  logic [D-1:0] RdAddr;
  logic [W-1:0] RdData;
  logic         OutValid;
  logic         OutReady;
  logic [D-1:0] OutAddr;
  logic [W-1:0] OutData;
  logic         Busy;
  logic         Done;

  modport master (
    input  DumpStart, FirstAddr, LastAddr, RdData, OutReady,
    output RdAddr, OutValid, OutAddr, OutData, Busy, Done
  );

  modport slave (
    output DumpStart, FirstAddr, LastAddr, RdData, OutReady,
    input  RdAddr, OutValid, OutAddr, OutData, Busy, Done
  );

endinterface

// File: rtl/regfile_dump.sv
// Walks a wrapping register range through the read port and streams
// (address, data) words to a valid/ready sink, one word per two cycles.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int W = REG_W,
  parameter int D = REG_D
) (
  input logic            Clk,
  input logic            Reset,
  regfile_dump_if.master dif
);

  dump_state_t  state_q, state_d;
  logic [D-1:0] ptr_q, ptr_d;
  logic [D-1:0] last_q, last_d;
  logic         out_valid_q, out_valid_d;
  logic [D-1:0] out_addr_q, out_addr_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dif.DumpStart) begin
          ptr_d   = dif.FirstAddr;
          last_d  = dif.LastAddr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        out_data_d  = dif.RdData;
        out_addr_d  = ptr_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && dif.OutReady) begin
          out_valid_d = 1'b0;
          if (ptr_q == last_q) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            // Natural D-bit overflow gives the wrap from 2^D-1 back to 0.
            ptr_d   = ptr_q + D'(1);
            state_d = LOAD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dif.RdAddr   = ptr_q;
  assign dif.OutValid = out_valid_q;
  assign dif.OutAddr  = out_addr_q;
  assign dif.OutData  = out_data_q;
  assign dif.Busy     = busy_q;
  assign dif.Done     = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file feeds the read port and
// each dump is compared word-by-word against a list built from the range rules.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int NREG = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_dump_if #(.W(W), .D(D)) dif ();

  regfile_dump #(.W(W), .D(D)) dut (
    .Clk  (clk),
    .Reset(rst),
    .dif  (dif)
  );

  logic [W-1:0] rf [NREG];
  logic         rf_we;
  logic [D-1:0] rf_wa;
  logic [W-1:0] rf_wd;

  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;
  assign dif.RdData = rf[dif.RdAddr];

  logic [W-1:0] ref_rf [NREG];
  int checks = 0;
  int errors = 0;

  task automatic write_reg(input logic [D-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    rf_we = 1'b1; rf_wa = a; rf_wd = d;
    ref_rf[a] = d;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  // mode: 0 ready always, 1 ready pattern 0,0,1 per word, 2 random ready.
  task automatic run_dump(input string name, input logic [D-1:0] first, input logic [D-1:0] last,
                          input int mode, input int restart_t, input int abort_word,
                          input int wr_t, input logic [W-1:0] wr_data,
                          input logic exp0_en, input logic [W-1:0] exp0);
    logic [D-1:0] exp_a [$];
    logic [W-1:0] exp_d [$];
    logic [D-1:0] a;
    int n, idx, t, busy_cnt, stall;
    logic done_seen, pend, r;

    n = int'(D'(last - first)) + 1;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(a);
      exp_d.push_back(ref_rf[a]);
      a = a + D'(1);
    end
    if (exp0_en) exp_d[0] = exp0;

    @(negedge clk);
    dif.DumpStart = 1'b1; dif.FirstAddr = first; dif.LastAddr = last;
    if (wr_t == 0) begin rf_we = 1'b1; rf_wa = first; rf_wd = wr_data; end
    t = 0; idx = 0; busy_cnt = 0; stall = 0; done_seen = 1'b0; pend = 1'b0;

    while (!done_seen && t < 400) begin
      @(negedge clk);
      t++;
      dif.DumpStart = 1'b0;
      rf_we = 1'b0;
      if (t == restart_t) begin
        dif.DumpStart = 1'b1; dif.FirstAddr = 4'd9; dif.LastAddr = 4'd9;
      end
      if (t == wr_t) begin rf_we = 1'b1; rf_wa = first; rf_wd = wr_data; end
      if (dif.Busy) busy_cnt++;
      if (pend) begin
        checks++;
        if (dif.OutValid !== 1'b1) begin
          errors++;
          $display("FAIL %s valid_hold t=%0d: OutValid=%b required 1", name, t, dif.OutValid);
        end
      end
      if (dif.OutValid === 1'b1) begin
        checks++;
        if (idx >= n) begin
          errors++;
          $display("FAIL %s extra_word t=%0d: got (%0d,%h) beyond %0d words", name, t, dif.OutAddr, dif.OutData, n);
        end else if (dif.OutAddr !== exp_a[idx] || dif.OutData !== exp_d[idx]) begin
          errors++;
          $display("FAIL %s word%0d t=%0d: got (%0d,%h) required (%0d,%h)", name, idx, t,
                   dif.OutAddr, dif.OutData, exp_a[idx], exp_d[idx]);
        end
        if (idx == abort_word) begin
          rst = 1'b1;
          @(negedge clk);
          checks++;
          if (dif.OutValid !== 1'b0 || dif.Busy !== 1'b0 || dif.Done !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: valid=%b busy=%b done=%b required 0,0,0", name, dif.OutValid, dif.Busy, dif.Done);
          end
          rst = 1'b0;
          dif.OutReady = 1'b0;
          return;
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = (stall == 2);
          default: r = 1'($urandom_range(0, 1));
        endcase
        dif.OutReady = r;
        if (r) begin idx++; stall = 0; pend = 1'b0; end
        else begin stall++; pend = 1'b1; end
      end else begin
        dif.OutReady = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (dif.Done === 1'b1) done_seen = 1'b1;
    end

    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s done_timeout: no Done within %0d cycles", name, t);
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s word_count: got %0d required %0d", name, idx, n);
    end
    checks++;
    if (busy_cnt != t) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, t);
    end
    if (mode == 0) begin
      checks++;
      if (t != 2 * n + 1) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d required %0d", name, t, 2 * n + 1);
      end
    end
    @(negedge clk);
    dif.OutReady = 1'b0;
    checks++;
    if (dif.Busy !== 1'b0 || dif.Done !== 1'b0 || dif.OutValid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: busy=%b done=%b valid=%b required 0,0,0", name, dif.Busy, dif.Done, dif.OutValid);
    end
    if (wr_t >= 0) ref_rf[first] = wr_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.OutValid !== 1'b0 || dif.Busy !== 1'b0 || dif.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b required 0,0,0", dif.OutValid, dif.Busy, dif.Done);
    end
    checks++;
    if (dif.OutAddr !== 4'd0 || dif.OutData !== 8'd0 || dif.RdAddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: OutAddr=%h OutData=%h RdAddr=%h required 0,00,0", dif.OutAddr, dif.OutData, dif.RdAddr);
    end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < NREG; i++) write_reg(D'(i), 8'h10 + W'(i));
    run_dump("full", 4'd0, 4'd15, 0, -1, -1, -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_single_and_wrap();
    run_dump("single", 4'd5, 4'd5, 0, -1, -1, -1, 8'h00, 1'b0, 8'h00);
    run_dump("wrap", 4'd14, 4'd1, 0, -1, -1, -1, 8'h00, 1'b0, 8'h00);
    run_dump("all_wrap", 4'd9, 4'd8, 0, -1, -1, -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    run_dump("stall", 4'd2, 4'd4, 1, -1, -1, -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_restart_and_abort();
    run_dump("ignore_abort", 4'd0, 4'd7, 0, 4, 3, -1, 8'h00, 1'b0, 8'h00);
    run_dump("after_abort", 4'd0, 4'd3, 0, -1, -1, -1, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_write_race();
    run_dump("wr_same_cycle", 4'd6, 4'd6, 0, -1, -1, 1, 8'hAA, 1'b1, 8'h16);
    write_reg(4'd6, 8'h16);
    run_dump("wr_cycle_before", 4'd6, 4'd6, 0, -1, -1, 0, 8'hAA, 1'b1, 8'hAA);
  endtask

  task automatic test_random();
    for (int i = 0; i < NREG; i++) write_reg(D'(i), W'($urandom));
    for (int k = 0; k < 6; k++)
      run_dump("random", D'($urandom), D'($urandom), 2, -1, -1, -1, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
    dif.DumpStart = 1'b0; dif.FirstAddr = '0; dif.LastAddr = '0; dif.OutReady = 1'b0;
    test_reset();
    test_full_range();
    test_single_and_wrap();
    test_backpressure();
    test_restart_and_abort();
    test_write_race();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
